// File: rtl/sga_pkg.sv
// Shared constants for the snake-body RAM arbiter: requester indices and lock FSM encoding.
package sga_pkg;

   localparam int unsigned REQ_MOVE   = 0;
   localparam int unsigned REQ_COLL   = 1;
   localparam int unsigned REQ_RENDER = 2;

   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

endpackage

// File: rtl/sga_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester after ptr.
module sga_rr_pick #(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt_c
);

   int unsigned idx;
   logic        found;

   // Search order ptr+1, ptr+2, ... wrapping, so the last winner goes to the back.
   always_comb begin
      gnt_c = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = (32'(ptr) + i) % N_REQ;
         if (!found && req[PTR_W'(idx)]) begin
            gnt_c[PTR_W'(idx)] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sga_ram_arbiter.sv
// Single-port body-RAM arbiter for move engine, collision scanner and render reader.
// Optional burst lock enabled by defining SGA_ARB_LOCK_EN.
module sga_ram_arbiter
   import sga_pkg::*;
#(
   parameter int unsigned N_REQ     = 3,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned DATA_W    = 6,
   parameter int unsigned MOVE_PRIO = 0
) (
   input  logic                      clock,
   input  logic                      restart,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          we,
   input  logic [N_REQ*ADDR_W-1:0]   addr,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   input  logic [N_REQ-1:0]          lock,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic                      ram_we,
   output logic [DATA_W-1:0]         ram_wdata,
   input  logic [DATA_W-1:0]         ram_rdata,
   output logic                      busy,
   output logic [1:0]                db_owner
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [N_REQ-1:0] rvalid_q;
   logic [1:0]       db_owner_q;
   logic [N_REQ-1:0] rr_gnt;
   logic [N_REQ-1:0] arb_gnt;
   logic [N_REQ-1:0] sel_gnt;
   logic [PTR_W-1:0] gnt_idx;
   logic             transfer;

   sga_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .gnt_c (rr_gnt)
   );

   // Move engine pre-empts the rotation when MOVE_PRIO is set.
   always_comb begin
      arb_gnt = rr_gnt;
      if ((MOVE_PRIO != 0) && req[PTR_W'(REQ_MOVE)]) begin
         arb_gnt                     = '0;
         arb_gnt[PTR_W'(REQ_MOVE)]   = 1'b1;
      end
   end

`ifdef SGA_ARB_LOCK_EN
   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic [PTR_W-1:0] owner_q;
   logic [PTR_W-1:0] owner_d;
   logic             lock_hold;

   // A held lock restricts the grant to the owner; dropping it arbitrates normally.
   always_comb begin
      lock_hold = (state_q == ST_LOCKED) && lock[owner_q];
      sel_gnt   = arb_gnt;
      if (lock_hold) begin
         sel_gnt          = '0;
         sel_gnt[owner_q] = req[owner_q];
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if ((state_q == ST_LOCKED) && !lock[owner_q]) begin
         state_d = ST_UNLOCKED;
      end
      if ((state_d == ST_UNLOCKED) && transfer && lock[gnt_idx]) begin
         state_d = ST_LOCKED;
         owner_d = gnt_idx;
      end
   end

   always_ff @(posedge clock) begin
      if (restart) begin
         state_q <= ST_UNLOCKED;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = ^lock;
   assign sel_gnt     = arb_gnt;
`endif

   assign gnt      = restart ? '0 : sel_gnt;
   assign transfer = |gnt;
   assign busy     = transfer;

   // RAM port mux: idle port is fully zeroed.
   always_comb begin
      gnt_idx   = '0;
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (gnt[PTR_W'(k)]) begin
            gnt_idx   = PTR_W'(k);
            ram_addr  = ADDR_W'(addr >> (k * ADDR_W));
            ram_wdata = DATA_W'(wdata >> (k * DATA_W));
            ram_we    = we[PTR_W'(k)];
         end
      end
   end

   // Restart squashes an in-flight read in the same cycle it is asserted.
   assign rvalid   = restart ? '0 : rvalid_q;
   assign rdata    = ram_rdata;
   assign db_owner = db_owner_q;

   always_ff @(posedge clock) begin
      if (restart) begin
         ptr_q      <= PTR_W'(N_REQ - 1);
         rvalid_q   <= '0;
         db_owner_q <= '0;
      end else begin
         rvalid_q <= gnt & ~we;
         if (transfer) begin
            ptr_q      <= gnt_idx;
            db_owner_q <= 2'(gnt_idx);
         end
      end
   end

endmodule
